// File: rtl/cms_stream_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC AXI-Stream sources share one sink.
// A source holds the grant until its packet ends (own tlast or beat watchdog).
module cms_stream_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned SRC_ID_WIDTH  = 1,
    parameter int unsigned MAX_PKT_BEATS = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_enable,
    input  logic [NUM_SRC-1:0]              S_AXIS_tvalid,
    output logic [NUM_SRC-1:0]              S_AXIS_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [NUM_SRC-1:0]              S_AXIS_tlast,
    output logic                            M_AXIS_tvalid,
    input  logic                            M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]           M_AXIS_tdata,
    output logic                            M_AXIS_tlast,
    output logic [SRC_ID_WIDTH-1:0]         M_AXIS_tid,
    output logic [NUM_SRC-1:0]              grant,
    output logic [15:0]                     forced_tlast_count
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_PKT_BEATS) + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]              state;
    logic [SRC_ID_WIDTH-1:0] last_grant;
    logic [SRC_ID_WIDTH-1:0] gidx;
    logic [SRC_ID_WIDTH-1:0] next_idx;
    logic [NUM_SRC-1:0]      next_onehot;
    logic                    found;
    logic [NUM_SRC-1:0]      cand;
    logic [CNT_WIDTH-1:0]    beat_cnt;
    logic                    out_free;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    accept;
    logic                    wd_end;
    logic                    eop;

    assign cand     = S_AXIS_tvalid & src_enable;
    assign out_free = ~M_AXIS_tvalid | M_AXIS_tready;

    // Cyclic search starting just after the previously granted source.
    always_comb begin
        int unsigned idx;
        found       = 1'b0;
        next_idx    = '0;
        next_onehot = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!found && cand[idx]) begin
                found            = 1'b1;
                next_idx         = SRC_ID_WIDTH'(idx);
                next_onehot      = '0;
                next_onehot[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gidx == SRC_ID_WIDTH'(i)) begin
                sel_valid = S_AXIS_tvalid[i];
                sel_last  = S_AXIS_tlast[i];
                sel_data  = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign S_AXIS_tready = grant & {NUM_SRC{out_free}};
    assign accept        = (state == BUSY) && sel_valid && out_free;
    assign wd_end        = (beat_cnt == CNT_WIDTH'(MAX_PKT_BEATS - 1));
    assign eop           = sel_last || wd_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= SRC_ID_WIDTH'(NUM_SRC - 1);
            gidx               <= '0;
            grant              <= '0;
            beat_cnt           <= '0;
            M_AXIS_tvalid      <= 1'b0;
            M_AXIS_tdata       <= '0;
            M_AXIS_tlast       <= 1'b0;
            M_AXIS_tid         <= '0;
            forced_tlast_count <= '0;
        end else begin
            // Output register drains independently of the FSM, so the last beat
            // of a packet can still be pending while the next grant is chosen.
            if (accept) begin
                M_AXIS_tvalid <= 1'b1;
                M_AXIS_tdata  <= sel_data;
                M_AXIS_tlast  <= eop;
                M_AXIS_tid    <= gidx;
            end else if (M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= next_onehot;
                        gidx  <= next_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (eop) begin
                            last_grant <= gidx;
                            grant      <= '0;
                            beat_cnt   <= '0;
                            state      <= IDLE;
                            if (!sel_last && forced_tlast_count != 16'hFFFF)
                                forced_tlast_count <= forced_tlast_count + 16'd1;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cms_stream_arbiter.sv
// Scoreboard bench for cms_stream_arbiter: per-source expected beat queues,
// round-robin grant model and output hold/interleave checks.
module tb_cms_stream_arbiter;

    localparam int DW   = 16;
    localparam int NS   = 3;
    localparam int IDW  = 2;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_en;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS-1:0]     s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic [IDW-1:0]    m_tid;
    logic [NS-1:0]     grant;
    logic [15:0]       forced;

    cms_stream_arbiter #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_ID_WIDTH(IDW), .MAX_PKT_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .src_enable(src_en),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
        .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast), .M_AXIS_tid(m_tid),
        .grant(grant), .forced_tlast_count(forced)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected {tlast, tdata} per source; an output packet closes on the source
    // tlast or after MAXB beats of one source packet, whichever comes first
    logic [DW:0] exp_q [NS][$];
    int          pkt_req [NS][$];
    int          exp_tid_q [$];
    int          exp_forced = 0;
    int          pend = 0;
    int          valid_pct = 100;
    int          ready_mode = 0;
    int          ready_pct = 100;
    int          out_beats = 0;

    // ---------------- source drivers ----------------
    initial begin
        int          rem [NS];
        int          chunk [NS];
        bit          have [NS];
        logic [NS-1:0] hs;
        logic [DW-1:0] d;
        bit          last, eop;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        for (int i = 0; i < NS; i++) begin rem[i] = 0; chunk[i] = 0; have[i] = 0; end
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < NS; i++) begin
                    exp_q[i].delete();
                    pkt_req[i].delete();
                    rem[i] = 0; chunk[i] = 0; have[i] = 0;
                end
                s_tvalid   = '0;
                exp_forced = 0;
                pend       = 0;
                continue;
            end
            pend = 0;
            for (int i = 0; i < NS; i++) begin
                if (have[i] && hs[i]) begin
                    have[i]     = 0;
                    s_tvalid[i] = 1'b0;
                end
                if (!have[i]) begin
                    if (rem[i] == 0 && pkt_req[i].size() > 0) rem[i] = pkt_req[i].pop_front();
                    if (rem[i] > 0 && $urandom_range(99) < valid_pct) begin
                        d = DW'($urandom);
                        last = (rem[i] == 1);
                        rem[i]--;
                        chunk[i]++;
                        eop = last || (chunk[i] == MAXB);
                        if (eop) begin
                            if (!last) exp_forced++;
                            chunk[i] = 0;
                        end
                        exp_q[i].push_back({eop, d});
                        s_tdata[i*DW +: DW] = d;
                        s_tlast[i]  = last;
                        s_tvalid[i] = 1'b1;
                        have[i]     = 1;
                    end
                end
                pend += rem[i];
            end
        end
    end

    // ---------------- sink ready ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       m_tready = ($urandom_range(99) < ready_pct);
                2:       m_tready = ~m_tready;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit            prev_v, prev_r, prev_l, open;
        logic [DW-1:0] prev_d;
        logic [IDW-1:0] prev_t;
        logic [NS-1:0] prev_grant, prev_cand;
        int            last_src, open_tid, w, idx, t, et;
        logic [DW:0]   e;
        prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0; prev_t = '0;
        prev_grant = '0; prev_cand = '0; last_src = NS - 1; open = 0; open_tid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0; prev_grant = '0; last_src = NS - 1; open = 0;
                prev_cand = s_tvalid & src_en;
                continue;
            end
            if (prev_v && !prev_r) begin
                checks++;
                if (!(m_tvalid && m_tdata == prev_d && m_tlast == prev_l && m_tid == prev_t)) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0h l=%0b id=%0d expected v=1 d=%0h l=%0b id=%0d",
                             m_tvalid, m_tdata, m_tlast, m_tid, prev_d, prev_l, prev_t);
                end
            end
            if (prev_grant == '0 && grant != '0) begin
                w = -1;
                for (int k = 1; k <= NS; k++) begin
                    idx = (last_src + k) % NS;
                    if (w < 0 && prev_cand[idx]) w = idx;
                end
                checks++;
                if (w < 0 || grant != NS'(1 << w)) begin
                    errors++;
                    $display("FAIL grant_rr: got %b expected winner %0d (cand %b, last %0d)",
                             grant, w, prev_cand, last_src);
                end
                if (w >= 0) last_src = w;
            end
            if (m_tvalid && m_tready) begin
                out_beats++;
                t = int'(m_tid);
                checks++;
                if (t >= NS || exp_q[t].size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected beat id=%0d d=%0h expected none", t, m_tdata);
                end else begin
                    e = exp_q[t].pop_front();
                    if ({m_tlast, m_tdata} !== e) begin
                        errors++;
                        $display("FAIL beat: id=%0d got l=%0b d=%0h expected l=%0b d=%0h",
                                 t, m_tlast, m_tdata, e[DW], e[DW-1:0]);
                    end
                end
                if (open) begin
                    checks++;
                    if (t != open_tid) begin
                        errors++;
                        $display("FAIL interleave: got id=%0d expected id=%0d", t, open_tid);
                    end
                end
                open = !m_tlast;
                open_tid = t;
                if (exp_tid_q.size() > 0) begin
                    et = exp_tid_q.pop_front();
                    checks++;
                    if (t != et) begin
                        errors++;
                        $display("FAIL tid_seq: got %0d expected %0d", t, et);
                    end
                end
            end
            prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast;
            prev_t = m_tid; prev_grant = grant; prev_cand = s_tvalid & src_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end of run expected $finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "global timeout");
    end

    // ---------------- helpers ----------------
    function automatic bit drained();
        bit ok = (pend == 0) && (s_tvalid == '0) && !m_tvalid && (grant == '0);
        for (int i = 0; i < NS; i++) if (exp_q[i].size() != 0 || pkt_req[i].size() != 0) ok = 0;
        return ok;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (!drained()) begin
            errors++;
            $display("FAIL %s_drain: got pending after %0d cycles expected empty", name, budget);
        end
        checks++;
        if (forced != 16'(exp_forced)) begin
            errors++;
            $display("FAIL %s_forced: got %0d expected %0d", name, forced, exp_forced);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_en(input logic [NS-1:0] v);
        @(posedge clk); #1; src_en = v;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, lat, f0, ob0;
        bit saw1;
        rst = 1'b1;
        src_en = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_tvalid || grant != '0 || forced != '0 || s_tready != '0 || m_tdata != '0 ||
            m_tlast || m_tid != '0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b g=%b f=%0d rdy=%b d=%0h l=%0b id=%0d expected all 0",
                     m_tvalid, grant, forced, s_tready, m_tdata, m_tlast, m_tid);
        end
        rst = 1'b0;

        // 1: single 3-beat packet, latency grant + register
        pkt_req[0].push_back(3);
        n = 0;
        while (!s_tvalid[0] && n < 20) begin @(negedge clk); n++; end
        lat = 0;
        while (!m_tvalid && lat < 10) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 2", lat);
        end
        wait_drain("t1", 100);

        // 2: two sources streaming 2-beat packets rotate per packet
        do_reset();
        for (int p = 0; p < 4; p++) begin
            pkt_req[0].push_back(2);
            pkt_req[1].push_back(2);
            exp_tid_q.push_back(0); exp_tid_q.push_back(0);
            exp_tid_q.push_back(1); exp_tid_q.push_back(1);
        end
        wait_drain("t2", 200);
        checks++;
        if (exp_tid_q.size() != 0) begin
            errors++;
            $display("FAIL t2_seq_len: got %0d left expected 0", exp_tid_q.size());
            exp_tid_q.delete();
        end

        // 3: toggling sink ready
        ready_mode = 2;
        pkt_req[0].push_back(4);
        wait_drain("t3", 100);
        ready_mode = 0;

        // 4: watchdog splits a 6-beat packet into 4 + 2
        f0 = int'(forced);
        pkt_req[1].push_back(6);
        wait_drain("t4", 100);
        checks++;
        if (int'(forced) - f0 != 1) begin
            errors++;
            $display("FAIL t4_forced_delta: got %0d expected 1", int'(forced) - f0);
        end

        // 5: disabled source is never granted; disable mid-packet completes the packet
        set_en(3'b001);
        pkt_req[1].push_back(4);
        pkt_req[0].push_back(3);
        saw1 = 0;
        repeat (40) begin @(negedge clk); if (grant[1]) saw1 = 1; end
        checks++;
        if (saw1 || exp_q[1].size() != 1 || exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL t5_blocked: got saw1=%0b q1=%0d q0=%0d expected 0,1,0",
                     saw1, exp_q[1].size(), exp_q[0].size());
        end
        pkt_req[0].push_back(4);
        n = 0;
        while (!(grant[0] && m_tvalid) && n < 50) begin @(negedge clk); n++; end
        set_en(3'b000);
        n = 0;
        while ((exp_q[0].size() != 0 || pend > 3 || grant[0]) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (exp_q[0].size() != 0 || grant[0]) begin
            errors++;
            $display("FAIL t5_midpkt: got q0=%0d grant=%b expected 0,000", exp_q[0].size(), grant);
        end
        set_en('1);
        wait_drain("t5", 200);

        // 6: reset on beat 2 of a 5-beat packet
        pkt_req[0].push_back(5);
        ob0 = out_beats;
        n = 0;
        while (out_beats - ob0 < 2 && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        checks++;
        if (m_tvalid || grant != '0) begin
            errors++;
            $display("FAIL t6_async: got v=%0b grant=%b expected 0,000", m_tvalid, grant);
        end
        @(negedge clk);
        rst = 1'b0;
        pkt_req[1].push_back(2);
        pkt_req[0].push_back(2);
        n = 0;
        while (grant == '0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (grant != 3'b001) begin
            errors++;
            $display("FAIL t6_first_grant: got %b expected 001", grant);
        end
        wait_drain("t6", 100);

        // random traffic: stalls, gaps, enable churn
        valid_pct  = 60;
        ready_mode = 1;
        ready_pct  = 70;
        for (int i = 0; i < NS; i++)
            for (int p = 0; p < 15; p++) pkt_req[i].push_back($urandom_range(7, 1));
        repeat (1500) begin
            @(posedge clk); #1;
            for (int i = 0; i < NS; i++) src_en[i] = ($urandom_range(99) < 75);
        end
        set_en('1);
        wait_drain("rand", 3000);
        valid_pct  = 100;
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
